// File: rtl/debug_bus_pkg.sv
// Shared helpers for the debug bus arbiter slice: width calculations used by
// the arbiter and its routing FIFO.
package debug_bus_pkg;

  // Index width for n items; a single item still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/debug_bus_id_fifo.sv
// Small FIFO of master indices that routes in-order slave responses back to
// the master that issued each granted request.
module debug_bus_id_fifo
  import debug_bus_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned IdWidth  = 1,
  localparam int unsigned PtrWidth = id_width(Depth),
  localparam int unsigned CntWidth = count_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [IdWidth-1:0]  push_data_i,
  input  logic                pop_i,
  output logic [IdWidth-1:0]  pop_data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] usage_o
);

  logic [IdWidth-1:0]  mem_q [Depth];
  logic [PtrWidth-1:0] wptr_q, rptr_q;
  logic [PtrWidth-1:0] wptr_next, rptr_next;
  logic [CntWidth-1:0] count_q;
  logic                do_push, do_pop;

  assign full_o  = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign usage_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth need not be a power of two, so pointers wrap explicitly.
  assign wptr_next = (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + 1'b1;
  assign rptr_next = (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + 1'b1;

  assign pop_data_o = mem_q[rptr_q];

  generate
    for (genvar gi = 0; gi < int'(Depth); gi++) begin : g_entry
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wptr_q == PtrWidth'(gi))) begin
          mem_q[gi] <= push_data_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_next;
      if (do_pop)  rptr_q <= rptr_next;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/debug_bus_arbiter.sv
// N-master to 1-slave round-robin arbiter for the req/gnt/rvalid debug bus,
// with grant locking and in-order response routing.
module debug_bus_arbiter
  import debug_bus_pkg::*;
#(
  parameter int unsigned NumMasters     = 2,
  parameter int unsigned AddrWidth      = 15,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdWidth  = id_width(NumMasters),
  localparam int unsigned BeWidth  = DataWidth / 8,
  localparam int unsigned CntWidth = count_width(MaxOutstanding)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumMasters-1:0]                m_req_i,
  input  logic [NumMasters-1:0][AddrWidth-1:0] m_addr_i,
  input  logic [NumMasters-1:0]                m_we_i,
  input  logic [NumMasters-1:0][DataWidth-1:0] m_wdata_i,
  input  logic [NumMasters-1:0][BeWidth-1:0]   m_be_i,
  output logic [NumMasters-1:0]                m_gnt_o,
  output logic [NumMasters-1:0]                m_rvalid_o,
  output logic [NumMasters-1:0][DataWidth-1:0] m_rdata_o,
  output logic                                 s_req_o,
  output logic [AddrWidth-1:0]                 s_addr_o,
  output logic                                 s_we_o,
  output logic [DataWidth-1:0]                 s_wdata_o,
  output logic [BeWidth-1:0]                   s_be_o,
  input  logic                                 s_gnt_i,
  input  logic                                 s_rvalid_i,
  input  logic [DataWidth-1:0]                 s_rdata_i,
  output logic                                 busy_o,
  output logic                                 err_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } req_t;

  typedef struct packed {
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
  } rsp_t;

  req_t m_reqs [NumMasters];
  rsp_t m_rsps [NumMasters];
  req_t sel_req;

  logic [IdWidth-1:0]  rr_q, sel_q;
  logic                lock_q, err_q;
  logic [IdWidth-1:0]  winner, cand, winner_inc;
  logic                found;
  int                  pos;
  logic                handshake, stall, resp_valid;
  logic                fifo_full, fifo_empty;
  logic [IdWidth-1:0]  head_id;
  logic [CntWidth-1:0] usage;

  // While a request waits for its grant the selection is frozen.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    pos    = 0;
    if (lock_q) begin
      winner = sel_q;
    end else begin
      for (int k = 0; k < int'(NumMasters); k++) begin
        pos = int'(rr_q) + k;
        if (pos >= int'(NumMasters)) pos = pos - int'(NumMasters);
        cand = IdWidth'(pos);
        if (!found && m_req_i[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  assign winner_inc = (int'(winner) == int'(NumMasters) - 1) ? '0 : winner + 1'b1;

  // No bypass: a full FIFO blocks requests even when a pop is in flight.
  assign s_req_o    = m_req_i[winner] && !fifo_full;
  assign handshake  = s_req_o && s_gnt_i;
  assign stall      = s_req_o && !s_gnt_i;
  assign resp_valid = s_rvalid_i && !fifo_empty;

  assign sel_req   = m_reqs[winner];
  assign s_addr_o  = sel_req.addr;
  assign s_we_o    = sel_req.we;
  assign s_wdata_o = sel_req.wdata;
  assign s_be_o    = sel_req.be;

  generate
    for (genvar gi = 0; gi < int'(NumMasters); gi++) begin : g_master
      assign m_reqs[gi]        = '{addr: m_addr_i[gi], we: m_we_i[gi],
                                   wdata: m_wdata_i[gi], be: m_be_i[gi]};
      assign m_rsps[gi].rvalid = resp_valid && (head_id == IdWidth'(gi));
      assign m_rsps[gi].rdata  = s_rdata_i;
      assign m_rvalid_o[gi]    = m_rsps[gi].rvalid;
      assign m_rdata_o[gi]     = m_rsps[gi].rdata;
      assign m_gnt_o[gi]       = handshake && (winner == IdWidth'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
      sel_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (handshake) rr_q <= winner_inc;
      lock_q <= stall;
      if (stall) sel_q <= winner;
      if (s_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  debug_bus_id_fifo #(
    .Depth   (MaxOutstanding),
    .IdWidth (IdWidth)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (handshake),
    .push_data_i (winner),
    .pop_i       (resp_valid),
    .pop_data_o  (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .usage_o     (usage)
  );

  assign busy_o = (usage != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Randomized bench for debug_bus_arbiter against a queue-based model of the
// round-robin, lock, full and response-routing rules.
module tb_debug_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 15;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int MO = 3;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [N-1:0]         m_req_i, m_we_i, m_gnt_o, m_rvalid_o;
  logic [N-1:0][AW-1:0] m_addr_i;
  logic [N-1:0][DW-1:0] m_wdata_i, m_rdata_o;
  logic [N-1:0][BW-1:0] m_be_i;
  logic                 s_req_o, s_we_o, s_gnt_i, s_rvalid_i, busy_o, err_o;
  logic [AW-1:0]        s_addr_o;
  logic [DW-1:0]        s_wdata_o, s_rdata_i;
  logic [BW-1:0]        s_be_o;

  debug_bus_arbiter #(
    .NumMasters     (N),
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .m_req_i    (m_req_i),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_wdata_i  (m_wdata_i),
    .m_be_i     (m_be_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_wdata_o  (s_wdata_o),
    .s_be_o     (s_be_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int rr   = 0;
  int sel  = 0;
  bit lock = 0;
  bit err  = 0;
  bit pending [N];
  int q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    rr = 0; sel = 0; lock = 0; err = 0;
    q.delete();
    for (int m = 0; m < N; m++) pending[m] = 0;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, advance model.
  task automatic cycle(input bit allow_new, input int force_m, input int gnt_pct,
                       input int rv_pct, input bit rv_when_empty);
    int w;
    bit found, full, exp_req, hs, rv_ok;
    logic [N-1:0] exp_gnt, exp_rv;
    @(negedge clk_i);
    for (int m = 0; m < N; m++) begin
      if (!pending[m] && (m == force_m || (allow_new && $urandom_range(99) < 50))) begin
        pending[m]   = 1;
        m_req_i[m]   = 1'b1;
        m_addr_i[m]  = AW'($urandom);
        m_we_i[m]    = 1'($urandom_range(1));
        m_wdata_i[m] = {$urandom, $urandom};
        m_be_i[m]    = BW'($urandom);
      end else if (!pending[m]) begin
        m_req_i[m] = 1'b0;
      end
    end
    s_gnt_i    = ($urandom_range(99) < gnt_pct);
    s_rvalid_i = ((q.size() != 0) || rv_when_empty) && ($urandom_range(99) < rv_pct);
    s_rdata_i  = {$urandom, $urandom};
    #1;
    w = 0; found = 0;
    if (lock) w = sel;
    else for (int k = 0; k < N; k++)
      if (!found && pending[(rr + k) % N]) begin w = (rr + k) % N; found = 1; end
    full    = (q.size() == MO);
    exp_req = pending[w] && !full;
    hs      = exp_req && s_gnt_i;
    exp_gnt = hs ? (N'(1) << w) : '0;
    rv_ok   = s_rvalid_i && (q.size() != 0);
    exp_rv  = rv_ok ? (N'(1) << q[0]) : '0;
    check("s_req", s_req_o, exp_req);
    check("m_gnt", m_gnt_o, exp_gnt);
    check("m_rvalid", m_rvalid_o, exp_rv);
    check("busy", busy_o, q.size() != 0);
    check("err", err_o, err);
    if (exp_req) begin
      check("s_addr", s_addr_o, m_addr_i[w]);
      check("s_we", s_we_o, m_we_i[w]);
      check("s_wdata", s_wdata_o, m_wdata_i[w]);
      check("s_be", s_be_o, m_be_i[w]);
    end
    if (rv_ok) check("m_rdata", m_rdata_o[q[0]], s_rdata_i);
    // Pop before push: a response can never belong to this cycle's grant.
    if (s_rvalid_i) begin
      if (rv_ok) begin
        $display("txn resp  master %0d rdata=%h", q[0], s_rdata_i);
        void'(q.pop_front());
      end else begin
        $display("txn resp  with nothing outstanding");
        err = 1;
      end
    end
    if (hs) begin
      $display("txn grant master %0d we=%0d addr=%h", w, m_we_i[w], m_addr_i[w]);
      pending[w] = 0;
      q.push_back(w);
      rr = (w + 1) % N;
    end
    lock = exp_req && !s_gnt_i;
    if (lock) sel = w;
  endtask

  initial begin
    bit any_pending;
    rst_ni     = 1'b0;
    m_req_i    = '0;
    m_addr_i   = '0;
    m_we_i     = '0;
    m_wdata_i  = '0;
    m_be_i     = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    model_reset();
    #3;
    check("reset s_req", s_req_o, 0);
    check("reset m_gnt", m_gnt_o, 0);
    check("reset m_rvalid", m_rvalid_o, 0);
    check("reset busy", busy_o, 0);
    check("reset err", err_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random traffic with varying slave grant and response rates
    for (int blk = 0; blk < 6; blk++) begin
      int gp, rp;
      gp = 30 + $urandom_range(70);
      rp = 15 + $urandom_range(75);
      for (int c = 0; c < 100; c++) cycle(1, -1, gp, rp, 0);
    end

    // Drain outstanding requests and responses
    for (int c = 0; c < 100; c++) begin
      any_pending = 0;
      for (int m = 0; m < N; m++) if (pending[m]) any_pending = 1;
      if (q.size() == 0 && !any_pending) break;
      cycle(0, -1, 100, 70, 0);
    end
    cycle(0, -1, 100, 0, 0);
    check("drained busy", busy_o, 0);

    // Response with nothing outstanding: sticky error
    for (int c = 0; c < 3; c++) cycle(0, -1, 100, 100, 1);

    // One grant outstanding, then asynchronous reset mid-cycle
    cycle(0, 1, 100, 0, 0);
    @(posedge clk_i);
    #2;
    check("busy before reset", busy_o, q.size() != 0);
    rst_ni = 1'b0;
    #1;
    check("async reset err", err_o, 0);
    check("async reset busy", busy_o, 0);
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // A stale response after reset release flags an error
    cycle(0, -1, 100, 100, 1);
    cycle(0, -1, 0, 0, 0);
    cycle(0, -1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
